// File: rtl/puf_sched_pkg.sv
// ---------------------------------------------------------------------------
// puf_sched_pkg
// Shared types and helpers for the PUF evaluation sequencer.
//   state_e    : sequencer state encoding
//   RESP_UNIT  : response bits for length code 0
//   RESP_W     : response register width (RESP_UNIT << 3)
//   resp_bits  : length code -> number of response bits N
//   imax       : integer maximum, used to size the shared counter
// ---------------------------------------------------------------------------
package puf_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_EVAL,
        ST_READ,
        ST_DONE
    } state_e;

    localparam int RESP_UNIT = 4;
    localparam int RESP_W    = RESP_UNIT << 3;

    function automatic int resp_bits(input logic [1:0] len);
        return RESP_UNIT << len;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/puf_sched_bitctr.sv
// ---------------------------------------------------------------------------
// puf_sched_bitctr
// Loadable down-counter with a zero flag. One instance times every state of
// the sequencer; it is reloaded on each state entry and saturates at zero.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   load_i    : load val_i this cycle (takes priority over decrement)
//   val_i     : reload value
//   cnt_o     : current count
//   zero_o    : count is zero
// ---------------------------------------------------------------------------
module puf_sched_bitctr #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/puf_eval_sched.sv
// ---------------------------------------------------------------------------
// puf_eval_sched
// Runs one challenge/response evaluation on the puf_super macro per accepted
// command: select/length setup with the PUF held in reset, serial challenge
// load on si (MSB first), settle after reset release, then N = RESP_UNIT<<len
// response bits collected from so into a right-aligned register.
//
// Optional feature (macro PUF_MAJVOTE_EN): three LOAD/EVAL/READ passes with a
// SETUP gap between them; the result is the bitwise majority of the passes and
// rsp_flip reports any disagreement. Without the macro: single pass, rsp_flip=0.
//
// Ports:
//   clk, rstn             : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake; cmd_sel, cmd_len, cmd_chal payload
//   rsp_valid/rsp_ready   : response handshake; rsp_data, rsp_flip payload
//   busy                  : sequencer not idle
//   puf_rstn, puf_reset   : PUF macro resets
//   puf_si, puf_so        : PUF serial challenge in / response out
//   puf_sel, puf_length   : PUF select and length code
// ---------------------------------------------------------------------------
module puf_eval_sched
    import puf_sched_pkg::*;
#(
    parameter int CHAL_W    = 16,
    parameter int SETUP_CYC = 2,
    parameter int EVAL_CYC  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_sel,
    input  logic [1:0]        cmd_len,
    input  logic [CHAL_W-1:0] cmd_chal,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RESP_W-1:0] rsp_data,
    output logic              rsp_flip,
    output logic              busy,
    output logic              puf_rstn,
    output logic              puf_reset,
    output logic              puf_si,
    output logic [1:0]        puf_sel,
    output logic [1:0]        puf_length,
    input  logic              puf_so
);

    localparam int CNT_MAX = imax(imax(CHAL_W, RESP_W), imax(SETUP_CYC, EVAL_CYC));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e              state_q, state_d;
    logic                run_q;
    logic [1:0]          sel_q, sel_d, len_q, len_d;
    logic [CHAL_W-1:0]   chal_q, chal_d;
    logic [RESP_W-1:0]   rsp_q, rsp_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0]    cnt, ld_val;
    logic                cnt_zero, cnt_load;
    logic                accept, chal_bit, read_bit, last_pass;

    // run_q rises on the first edge out of reset; it gates cmd_ready and
    // releases the PUF's own reset.
    assign cmd_ready = (state_q == ST_IDLE) && run_q;
    assign accept    = cmd_valid && cmd_ready;

    puf_sched_bitctr #(.W(CNT_W)) u_ctr (
        .clk    (clk),
        .rstn   (rstn),
        .load_i (cnt_load),
        .val_i  (ld_val),
        .cnt_o  (cnt),
        .zero_o (cnt_zero)
    );

    // During LOAD the counter runs CHAL_W-1..0, so it directly indexes the
    // challenge bit to send (MSB first).
    always_comb begin
        chal_bit = 1'b0;
        for (int k = 0; k < CHAL_W; k++) begin
            if (cnt == CNT_W'(k)) chal_bit = chal_q[k];
        end
    end

`ifdef PUF_MAJVOTE_EN
    logic [1:0]        pass_q, pass_d;
    logic [RESP_W-1:0] p0_q, p0_d, p1_q, p1_d;
    logic              flip_q, flip_d;
    logic              p0_bit, p1_bit;

    // In READ the counter runs N-1..0, which is also the position of the
    // current bit inside the right-aligned stored passes.
    always_comb begin
        p0_bit = 1'b0;
        p1_bit = 1'b0;
        for (int k = 0; k < RESP_W; k++) begin
            if (cnt == CNT_W'(k)) begin
                p0_bit = p0_q[k];
                p1_bit = p1_q[k];
            end
        end
    end

    assign last_pass = (pass_q == 2'd2);
    assign read_bit  = (p0_bit & p1_bit) | (p0_bit & puf_so) | (p1_bit & puf_so);
    assign rsp_flip  = flip_q;
`else
    assign last_pass = 1'b1;
    assign read_bit  = puf_so;
    assign rsp_flip  = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept)   state_d = ST_SETUP;
            ST_SETUP: if (cnt_zero) state_d = ST_LOAD;
            ST_LOAD:  if (cnt_zero) state_d = ST_EVAL;
            ST_EVAL:  if (cnt_zero) state_d = ST_READ;
            ST_READ:  if (cnt_zero) state_d = last_pass ? ST_DONE : ST_SETUP;
            ST_DONE:  if (rsp_valid_q && rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counter reloads on every state change with (duration - 1).
    assign cnt_load = (state_d != state_q);

    always_comb begin
        ld_val = '0;
        case (state_d)
            ST_SETUP: ld_val = CNT_W'(SETUP_CYC - 1);
            ST_LOAD:  ld_val = CNT_W'(CHAL_W - 1);
            ST_EVAL:  ld_val = CNT_W'(EVAL_CYC - 1);
            ST_READ:  ld_val = CNT_W'(resp_bits(len_q) - 1);
            default:  ld_val = '0;
        endcase
    end

    // Datapath next-state
    always_comb begin
        sel_d  = sel_q;
        len_d  = len_q;
        chal_d = chal_q;
        rsp_d  = rsp_q;
        // rsp_valid rises one cycle after entering DONE so the final shift
        // has settled; it falls on the handshake edge.
        rsp_valid_d = (state_q == ST_DONE) && !(rsp_valid_q && rsp_ready);
`ifdef PUF_MAJVOTE_EN
        pass_d = pass_q;
        p0_d   = p0_q;
        p1_d   = p1_q;
        flip_d = flip_q;
`endif
        if (accept) begin
            sel_d  = cmd_sel;
            len_d  = cmd_len;
            chal_d = cmd_chal;
            rsp_d  = '0;
`ifdef PUF_MAJVOTE_EN
            pass_d = 2'd0;
            p0_d   = '0;
            p1_d   = '0;
            flip_d = 1'b0;
`endif
        end
        if (state_q == ST_READ) begin
`ifdef PUF_MAJVOTE_EN
            unique case (pass_q)
                2'd0:    p0_d = {p0_q[RESP_W-2:0], puf_so};
                2'd1:    p1_d = {p1_q[RESP_W-2:0], puf_so};
                default: begin
                    rsp_d  = {rsp_q[RESP_W-2:0], read_bit};
                    flip_d = flip_q | (p0_bit ^ puf_so) | (p1_bit ^ puf_so);
                end
            endcase
            if (cnt_zero && !last_pass) pass_d = pass_q + 2'd1;
`else
            rsp_d = {rsp_q[RESP_W-2:0], read_bit};
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            run_q       <= 1'b0;
            sel_q       <= '0;
            len_q       <= '0;
            chal_q      <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
`ifdef PUF_MAJVOTE_EN
            pass_q      <= '0;
            p0_q        <= '0;
            p1_q        <= '0;
            flip_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            sel_q       <= sel_d;
            len_q       <= len_d;
            chal_q      <= chal_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef PUF_MAJVOTE_EN
            pass_q      <= pass_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            flip_q      <= flip_d;
`endif
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_q;
    assign puf_rstn   = run_q;
    assign puf_reset  = !((state_q == ST_EVAL) || (state_q == ST_READ));
    assign puf_si     = (state_q == ST_LOAD) && chal_bit;
    assign puf_sel    = sel_q;
    assign puf_length = len_q;

endmodule
